// File: rtl/seq_tx_if.sv
// Parallel frame load port for seq_tx: valid/ready handshake carrying data, length and repeat count.
interface seq_tx_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LEN_W = 4,
   parameter int unsigned REP_W = 4
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;
   logic [LEN_W-1:0] len;
   logic [REP_W-1:0] rep;

   modport master (output valid, output data, output len, output rep, input ready);
   modport slave  (input valid, input data, input len, input rep, output ready);
endinterface

// File: rtl/seq_tx.sv
// Bit-serial pattern transmitter: shifts a loaded frame out MSB-first, repeating it with optional
// idle gaps between repetitions.
module seq_tx #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LEN_W = 4,
   parameter int unsigned REP_W = 4,
   parameter int unsigned GAP   = 2
) (
   input  logic     clk_i,
   input  logic     rstn_i,
   seq_tx_if.slave  load,
   input  logic     abort_i,
   output logic     out_o,
   output logic     out_valid_o,
   output logic     busy_o,
   output logic     done_o
);

   localparam int unsigned DataPad = 2 ** LEN_W;
   localparam int unsigned GapW    = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [LEN_W-1:0] WidthL = LEN_W'(WIDTH);

   typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   idx_q, idx_d;
   logic [REP_W-1:0]   rep_q, rep_d;
   logic [GapW-1:0]    gap_q, gap_d;
   logic               out_q, out_d;
   logic               out_valid_q, out_valid_d;
   logic               done_q, done_d;

   // Zero-extended views so any LEN_W-wide index stays in range.
   logic [DataPad-1:0] data_ext;
   logic [DataPad-1:0] load_ext;
   logic [LEN_W-1:0]   len_eff;

   assign data_ext = DataPad'(data_q);
   assign load_ext = DataPad'(load.data);
   assign len_eff  = (load.len > WidthL) ? WidthL : load.len;

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      len_d       = len_q;
      idx_d       = idx_q;
      rep_d       = rep_q;
      gap_d       = gap_q;
      out_d       = 1'b0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!abort_i && load.valid) begin
               data_d = load.data;
               len_d  = len_eff;
               rep_d  = load.rep;
               if (len_eff == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = StShift;
                  idx_d       = len_eff - LEN_W'(1);
                  out_d       = load_ext[len_eff - LEN_W'(1)];
                  out_valid_d = 1'b1;
               end
            end
         end
         StShift: begin
            if (abort_i) begin
               state_d = StIdle;
            end else if (idx_q != '0) begin
               idx_d       = idx_q - LEN_W'(1);
               out_d       = data_ext[idx_q - LEN_W'(1)];
               out_valid_d = 1'b1;
            end else if (rep_q != '0) begin
               if (GAP > 0) begin
                  state_d = StGap;
                  gap_d   = GapW'(GAP - 1);
               end else begin
                  rep_d       = rep_q - REP_W'(1);
                  idx_d       = len_q - LEN_W'(1);
                  out_d       = data_ext[len_q - LEN_W'(1)];
                  out_valid_d = 1'b1;
               end
            end else begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         StGap: begin
            if (abort_i) begin
               state_d = StIdle;
            end else if (gap_q == '0) begin
               state_d     = StShift;
               rep_d       = rep_q - REP_W'(1);
               idx_d       = len_q - LEN_W'(1);
               out_d       = data_ext[len_q - LEN_W'(1)];
               out_valid_d = 1'b1;
            end else begin
               gap_d = gap_q - GapW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q     <= StIdle;
         data_q      <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         rep_q       <= '0;
         gap_q       <= '0;
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         rep_q       <= rep_d;
         gap_q       <= gap_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign load.ready  = (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);
   assign out_o       = out_q;
   assign out_valid_o = out_valid_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_seq_tx.sv
// Directed, table-driven bench for seq_tx: each vector drives one cycle of inputs and checks the
// registered outputs just after the following clock edge.
module tb_seq_tx;

   localparam int unsigned Width = 8;
   localparam int unsigned LenW  = 4;
   localparam int unsigned RepW  = 4;
   localparam int unsigned Gap   = 2;

   typedef struct {
      logic       rstn;
      logic       lv;
      logic [7:0] data;
      logic [3:0] len;
      logic [3:0] rep;
      logic       abort;
      logic [4:0] exp;   // {out, out_valid, busy, done, load_ready}
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn;
   logic abort;
   logic ser;
   logic ser_v;
   logic busy;
   logic done;

   seq_tx_if #(.WIDTH(Width), .LEN_W(LenW), .REP_W(RepW)) lif ();

   seq_tx #(.WIDTH(Width), .LEN_W(LenW), .REP_W(RepW), .GAP(Gap)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .load        (lif),
      .abort_i     (abort),
      .out_o       (ser),
      .out_valid_o (ser_v),
      .busy_o      (busy),
      .done_o      (done)
   );

   int   checks = 0;
   int   errors = 0;
   int   vid    = 0;
   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic lv, logic [7:0] d, logic [3:0] len,
                               logic [3:0] rep, logic ab, logic [4:0] exp);
      vec_t v;
      v.rstn  = r;
      v.lv    = lv;
      v.data  = d;
      v.len   = len;
      v.rep   = rep;
      v.abort = ab;
      v.exp   = exp;
      return v;
   endfunction

   // Idle cycle with nothing requested; only the expected outputs vary.
   function automatic vec_t idle(logic [4:0] exp);
      return mk(1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, exp);
   endfunction

   task automatic apply(input vec_t v, input string tag);
      logic [4:0] got;
      string      names[5];
      names[4] = "out";
      names[3] = "out_valid";
      names[2] = "busy";
      names[1] = "done";
      names[0] = "load_ready";
      rstn      = v.rstn;
      lif.valid = v.lv;
      lif.data  = v.data;
      lif.len   = v.len;
      lif.rep   = v.rep;
      abort     = v.abort;
      @(posedge clk);
      #1;
      got = {ser, ser_v, busy, done, lif.ready};
      for (int b = 0; b < 5; b++) begin
         checks++;
         if (got[b] !== v.exp[b]) begin
            errors++;
            $display("FAIL %s step %0d %s: got %b expected %b", tag, vid, names[b], got[b],
                     v.exp[b]);
         end
      end
      vid++;
   endtask

   // Output shorthands: {out, out_valid, busy, done, load_ready}
   localparam logic [4:0] OIdle = 5'b00001;
   localparam logic [4:0] ODone = 5'b00011;
   localparam logic [4:0] OB1   = 5'b11100;
   localparam logic [4:0] OB0   = 5'b01100;
   localparam logic [4:0] OGap  = 5'b00100;

   initial begin
      rstn      = 1'b0;
      abort     = 1'b0;
      lif.valid = 1'b0;
      lif.data  = '0;
      lif.len   = '0;
      lif.rep   = '0;

      // Reset and idle
      vecs.push_back(mk(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, OIdle));
      for (int i = 0; i < 5; i++) vecs.push_back(idle(OIdle));

      // 101, single frame
      vecs.push_back(mk(1'b1, 1'b1, 8'b0000_0101, 4'd3, 4'd0, 1'b0, OB1));
      vecs.push_back(idle(OB0));
      vecs.push_back(idle(OB1));
      vecs.push_back(idle(ODone));
      vecs.push_back(idle(OIdle));

      // 110 repeated 3 times with 2-cycle gaps: 110 00 110 00 110
      vecs.push_back(mk(1'b1, 1'b1, 8'b0000_0110, 4'd3, 4'd2, 1'b0, OB1));
      vecs.push_back(idle(OB1));
      vecs.push_back(idle(OB0));
      vecs.push_back(idle(OGap));
      vecs.push_back(idle(OGap));
      vecs.push_back(idle(OB1));
      vecs.push_back(idle(OB1));
      vecs.push_back(idle(OB0));
      vecs.push_back(idle(OGap));
      vecs.push_back(idle(OGap));
      vecs.push_back(idle(OB1));
      vecs.push_back(idle(OB1));
      vecs.push_back(idle(OB0));
      vecs.push_back(idle(ODone));

      // Load in the done cycle: 10, first bit on the very next cycle
      vecs.push_back(mk(1'b1, 1'b1, 8'b0000_0010, 4'd2, 4'd0, 1'b0, OB1));
      vecs.push_back(idle(OB0));
      vecs.push_back(idle(ODone));

      // len=0 loaded in the done cycle: no bits, done on the next cycle
      vecs.push_back(mk(1'b1, 1'b1, 8'hFF, 4'd0, 4'd3, 1'b0, ODone));
      vecs.push_back(idle(OIdle));

      // len=12 clamps to 8: 1000_0001
      vecs.push_back(mk(1'b1, 1'b1, 8'b1000_0001, 4'd12, 4'd0, 1'b0, OB1));
      for (int i = 0; i < 6; i++) vecs.push_back(idle(OB0));
      vecs.push_back(idle(OB1));
      vecs.push_back(idle(ODone));
      vecs.push_back(idle(OIdle));

      foreach (vecs[i]) apply(vecs[i], "table");

      // Abort on the 2nd bit of an 8-bit frame 1100_0011
      apply(mk(1'b1, 1'b1, 8'hC3, 4'd8, 4'd1, 1'b0, OB1), "abort");
      apply(idle(OB1), "abort");
      apply(mk(1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 1'b1, OIdle), "abort");
      apply(idle(OIdle), "abort");
      // Abort together with a load in IDLE: not accepted
      apply(mk(1'b1, 1'b1, 8'hFF, 4'd4, 4'd0, 1'b1, OIdle), "abort_idle");
      apply(idle(OIdle), "abort_idle");

      // Reset in the middle of a gap, then a clean frame 1101
      apply(mk(1'b1, 1'b1, 8'b0000_0110, 4'd3, 4'd1, 1'b0, OB1), "rst_gap");
      apply(idle(OB1), "rst_gap");
      apply(idle(OB0), "rst_gap");
      apply(idle(OGap), "rst_gap");
      apply(mk(1'b0, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, OIdle), "rst_gap");
      apply(idle(OIdle), "rst_gap");
      apply(mk(1'b1, 1'b1, 8'b0000_1101, 4'd4, 4'd0, 1'b0, OB1), "after_rst");
      apply(idle(OB1), "after_rst");
      apply(idle(OB0), "after_rst");
      apply(idle(OB1), "after_rst");
      apply(idle(ODone), "after_rst");
      apply(idle(OIdle), "after_rst");

      // Reset arriving in the done cycle clears done on the next cycle
      apply(mk(1'b1, 1'b1, 8'b0000_0001, 4'd1, 4'd0, 1'b0, OB1), "rst_done");
      apply(idle(ODone), "rst_done");
      apply(mk(1'b0, 1'b1, 8'h00, 4'd0, 4'd0, 1'b0, OIdle), "rst_done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_tx.md
# seq_tx

Bit-serial pattern transmitter: accepts a parallel frame (data, length, repeat count) through a valid/ready load port. It shifts the frame out MSB-first on a single-bit line, one bit per clock, with optional idle gaps between repetitions. It is the stimulus/driver end of the serial sequence-detection path and produces the `in` stream consumed by the Mealy detector FSMs in this codebase.

## Interface
- `WIDTH`, default 8: maximum frame length in bits.
- `LEN_W`, default 4: width of `load_len`. Must satisfy 2^LEN_W > WIDTH.
- `REP_W`, default 4: width of `load_rep`.
- `GAP`, default 2: idle cycles inserted between repetitions. 0 means back-to-back frames.

Ports:
- `clk`, input, 1: single clock; all logic on posedge.
- `rstn`, input, 1: reset, synchronous, active-low. Sampled on posedge `clk`.
- `load_valid`, input, 1: load request.
- `load_ready`, output, 1: block can accept a frame.
- `load_data`, input, WIDTH: frame bits. Bit `load_len-1` is sent first, bit 0 last.
- `load_len`, input, LEN_W: number of bits to send, 0..WIDTH.
- `load_rep`, input, REP_W: additional repetitions. Total frames sent = `load_rep`+1.
- `abort`, input, 1: cancel the current transfer.
- `out`, output, 1: serial bit. Registered.
- `out_valid`, output, 1: `out` carries a frame bit this cycle. Registered.
- `busy`, output, 1: state is not IDLE.
- `done`, output, 1: one-cycle pulse when the final bit of the final repetition has been sent.

## Operation
- States: IDLE, SHIFT, GAP. Encoding is free, but it must be a registered state variable.
- Reset (`rstn`=0 at a posedge) forces state IDLE and drives these values from the next cycle: `out`=0, `out_valid`=0, `done`=0, `busy`=0, `load_ready`=1. All internal counters and the data register are cleared.
- `load_ready` = (state==IDLE).
- A load is accepted when `load_valid` && `load_ready` at a posedge. It captures `load_data`, `load_len` and `load_rep`.
- Accept with `load_len`=0: no bits are sent and state stays IDLE. `done` pulses the next cycle.
- Accept with `load_len` > WIDTH: treated as WIDTH.
- IDLE → SHIFT on accept with len ≥ 1. On the same edge, `out` ← `data[len-1]` and `out_valid` ← 1. The bit index counter is loaded with len-1.
- SHIFT, each edge:
  - If index > 0: decrement the index and present `data[index-1]`.
  - If index == 0 (last bit is currently on `out`) and repetitions remain, with GAP > 0: go to GAP. `out`=0, `out_valid`=0, and the gap counter is loaded with GAP-1.
  - Same, with GAP == 0: restart at bit len-1 immediately. `out_valid` stays 1 and the repeat counter decrements.
  - If index == 0 and no repetitions remain: go to IDLE, with `out`=0, `out_valid`=0, `done`=1 for one cycle.
- GAP: `out`=0 and `out_valid`=0 throughout. When the gap counter reaches 0, the next edge presents bit len-1, decrements the repeat counter and enters SHIFT.
- `abort`=1 at any edge while not in IDLE: go to IDLE, `out`=0, `out_valid`=0, no `done`. In IDLE, `abort` has priority over a load: a simultaneous load is not accepted.
- The `done` cycle is an IDLE cycle, so a load presented in that cycle is accepted. The next frame's first bit then appears on the following cycle.
- `rstn` low mid-frame behaves like `abort`, and also clears `done` and all counters.
- Changes on `load_*` while busy are ignored.

## Timing
- Latency from the accept edge to the first bit on `out`: 1 cycle (valid in the cycle after the accept edge).
- A frame of len L occupies exactly L consecutive `out_valid` cycles.
- Total `busy` cycles = (R+1)·L + R·GAP, where R = captured `load_rep`.
- `done` is asserted in the cycle immediately after the last `out_valid` cycle, which is also the first cycle with `load_ready`=1.
- Minimum spacing between frames from separate loads: one idle cycle (the `done` cycle).
- No combinational path from inputs to `out`, `out_valid` or `done`. `load_ready` and `busy` decode only state.

## Test plan
- Reset, then hold `load_valid`=0 for 5 cycles → `out`=0, `out_valid`=0, `done`=0, `load_ready`=1 every cycle.
- Load data=8'b0000_0101, len=3, rep=0 → `out` = 1,0,1 on the 3 cycles after accept with `out_valid`=1, then `done`=1 for one cycle. A Mealy detector fed `out` asserts its output on the final bit.
- Load data=8'b0000_0110, len=3, rep=2, GAP=2 → `out` = 110 00 110 00 110. `out_valid` is low during the zeros. `busy` lasts 13 cycles and is followed by a single `done`.
- Back-to-back: issue a load in the `done` cycle → accepted, and its first bit appears on the next cycle. Also: len=0 load → no `out_valid`, `done` the next cycle.
- `abort` asserted on the 2nd bit of an 8-bit frame → `out_valid` drops at the next edge, no `done`, `load_ready`=1. A simultaneous `load_valid` with `abort` in IDLE is not accepted.
- `rstn` pulled low mid-GAP → all outputs at reset values on the next cycle. A new load afterwards transmits correctly from bit len-1.
